// File: rtl/mips_mc_control_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath.
// The controller receives the IR opcode and drives every datapath enable and select.
interface mips_mc_control_if;
    logic [5:0] OP;
    logic       PCWRITE;
    logic       PCWRITECOND;
    logic       IORD;
    logic       MEMREAD;
    logic       MEMWRITE;
    logic       IRWRITE;
    logic       MEMTOREG;
    logic       REGDST;
    logic       REGWRITE;
    logic       ALUSRCA;
    logic [1:0] ALUSRCB;
    logic [1:0] ALUOP;
    logic [1:0] PCSOURCE;
    logic [3:0] STATE;
    logic       ILLEGAL;

    modport master (
        input  OP,
        output PCWRITE, PCWRITECOND, IORD, MEMREAD, MEMWRITE, IRWRITE,
               MEMTOREG, REGDST, REGWRITE, ALUSRCA, ALUSRCB, ALUOP,
               PCSOURCE, STATE, ILLEGAL
    );

    modport slave (
        output OP,
        input  PCWRITE, PCWRITECOND, IORD, MEMREAD, MEMWRITE, IRWRITE,
               MEMTOREG, REGDST, REGWRITE, ALUSRCA, ALUSRCB, ALUOP,
               PCSOURCE, STATE, ILLEGAL
    );
endinterface

// File: rtl/mips_mc_control.sv
// Main control FSM of the multicycle MIPS core: sequences one instruction over
// 3-5 cycles and decodes all datapath enables/selects from the registered state.
//
// state  | meaning
// FETCH  | read instruction, load IR, PC <= PC+4
// DECODE | read registers, branch target into ALUOut, dispatch on opcode
// MEMADR | effective address for lw/sw
// MEMRD  | data memory read at ALUOut
// MEMWB  | write MDR into rt
// MEMWR  | data memory write at ALUOut
// RTEX   | R-type ALU operation (funct)
// RTWB   | write ALUOut into rd
// BEQ    | compare A/B, PC <= ALUOut if zero
// JMP    | PC <= jump target
// ADDIEX | A + sext(imm)
// ADDIWB | write ALUOut into rt
module mips_mc_control #(
    parameter bit ENABLE_ADDI = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    mips_mc_control_if.master     bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQ    = 4'd8,
        S_JMP    = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t state_q, state_d;

    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca, illegal;
    logic [1:0] alusrcb, aluop, pcsource;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = S_FETCH;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = 2'b00;
        pcsource    = 2'b00;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                irwrite = 1'b1;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                // ILLEGAL is the one output that looks at OP, and only in this state.
                if (bus.OP == OP_RTYPE)                         state_d = S_RTEX;
                else if (bus.OP == OP_LW || bus.OP == OP_SW)    state_d = S_MEMADR;
                else if (bus.OP == OP_BEQ)                      state_d = S_BEQ;
                else if (bus.OP == OP_J)                        state_d = S_JMP;
                else if (ENABLE_ADDI && bus.OP == OP_ADDI)      state_d = S_ADDIEX;
                else begin
                    state_d = S_FETCH;
                    illegal = 1'b1;
                end
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (bus.OP == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_RTEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = S_RTWB;
            end
            S_RTWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BEQ: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
            end
            S_JMP: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Enables are masked by RST directly so nothing fires while reset is held,
    // even though the state register already sits in FETCH.
    assign bus.PCWRITE     = pcwrite     & ~RST;
    assign bus.PCWRITECOND = pcwritecond & ~RST;
    assign bus.MEMREAD     = memread     & ~RST;
    assign bus.MEMWRITE    = memwrite    & ~RST;
    assign bus.IRWRITE     = irwrite     & ~RST;
    assign bus.REGWRITE    = regwrite    & ~RST;
    assign bus.ILLEGAL     = illegal     & ~RST;
    assign bus.IORD        = iord;
    assign bus.MEMTOREG    = memtoreg;
    assign bus.REGDST      = regdst;
    assign bus.ALUSRCA     = alusrca;
    assign bus.ALUSRCB     = alusrcb;
    assign bus.ALUOP       = aluop;
    assign bus.PCSOURCE    = pcsource;
    assign bus.STATE       = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: one DUT with addi enabled, one with it
// disabled, both fed the same opcode and reset in lockstep.
module tb_mips_mc_control;

    logic       CLK;
    logic       RST;
    logic [5:0] op;
    int         tests;
    int         fails;

    mips_mc_control_if m_if ();
    mips_mc_control_if n_if ();

    assign m_if.OP = op;
    assign n_if.OP = op;

    mips_mc_control #(.ENABLE_ADDI(1'b1)) dut_m (.CLK(CLK), .RST(RST), .bus(m_if));
    mips_mc_control #(.ENABLE_ADDI(1'b0)) dut_n (.CLK(CLK), .RST(RST), .bus(n_if));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic test_reset();
        RST = 1'b1;
        op  = 6'b100011;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        tests++;
        if (m_if.STATE !== 4'd0) begin
            fails++; $display("FAIL reset_state: got %0d expected 0", m_if.STATE);
        end
        tests++;
        if ({m_if.PCWRITE, m_if.PCWRITECOND, m_if.MEMREAD, m_if.MEMWRITE,
             m_if.IRWRITE, m_if.REGWRITE, m_if.ILLEGAL} !== 7'b0) begin
            fails++; $display("FAIL reset_enables: got %b expected 0000000",
                {m_if.PCWRITE, m_if.PCWRITECOND, m_if.MEMREAD, m_if.MEMWRITE,
                 m_if.IRWRITE, m_if.REGWRITE, m_if.ILLEGAL});
        end
        tests++;
        if (m_if.ALUSRCB !== 2'b01) begin
            fails++; $display("FAIL reset_alusrcb: got %b expected 01", m_if.ALUSRCB);
        end
        RST = 1'b0;
        #1;
        tests++;
        if ({m_if.PCWRITE, m_if.MEMREAD, m_if.IRWRITE, m_if.ALUSRCA, m_if.ALUOP, m_if.PCSOURCE}
            !== 8'b1110_0000) begin
            fails++; $display("FAIL release_fetch: got %b expected 11100000",
                {m_if.PCWRITE, m_if.MEMREAD, m_if.IRWRITE, m_if.ALUSRCA, m_if.ALUOP, m_if.PCSOURCE});
        end
    endtask

    task automatic test_lw();
        int exp_s[5] = '{0, 1, 2, 3, 4};
        op = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (m_if.STATE !== 4'(exp_s[i])) begin
                fails++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, m_if.STATE, exp_s[i]);
            end
            tests++;
            if (m_if.REGWRITE !== (exp_s[i] == 4) || m_if.MEMTOREG !== (exp_s[i] == 4)) begin
                fails++; $display("FAIL lw_wb[%0d]: got regwrite=%b memtoreg=%b expected %b",
                    i, m_if.REGWRITE, m_if.MEMTOREG, exp_s[i] == 4);
            end
            if (exp_s[i] == 3) begin
                tests++;
                if (m_if.MEMREAD !== 1'b1 || m_if.IORD !== 1'b1) begin
                    fails++; $display("FAIL lw_memrd: got memread=%b iord=%b expected 1 1",
                        m_if.MEMREAD, m_if.IORD);
                end
            end
            @(negedge CLK);
        end
        tests++;
        if (m_if.STATE !== 4'd0) begin
            fails++; $display("FAIL lw_end: got %0d expected 0", m_if.STATE);
        end
    endtask

    task automatic test_rtype();
        int exp_s[4] = '{0, 1, 6, 7};
        op = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (m_if.STATE !== 4'(exp_s[i])) begin
                fails++; $display("FAIL rt_state[%0d]: got %0d expected %0d", i, m_if.STATE, exp_s[i]);
            end
            tests++;
            if (m_if.ALUOP !== ((exp_s[i] == 6) ? 2'b10 : 2'b00)) begin
                fails++; $display("FAIL rt_aluop[%0d]: got %b", i, m_if.ALUOP);
            end
            tests++;
            if (m_if.REGWRITE !== (exp_s[i] == 7) || m_if.REGDST !== (exp_s[i] == 7)) begin
                fails++; $display("FAIL rt_wb[%0d]: got regwrite=%b regdst=%b expected %b",
                    i, m_if.REGWRITE, m_if.REGDST, exp_s[i] == 7);
            end
            @(negedge CLK);
        end
        tests++;
        if (m_if.STATE !== 4'd0) begin
            fails++; $display("FAIL rt_end: got %0d expected 0", m_if.STATE);
        end
    endtask

    task automatic test_back_to_back();
        int         exp_s[11] = '{0, 1, 2, 5, 0, 1, 8, 0, 1, 9, 0};
        logic [5:0] ops[11]   = '{6'b101011, 6'b101011, 6'b101011, 6'b101011,
                                  6'b000100, 6'b000100, 6'b000100,
                                  6'b000010, 6'b000010, 6'b000010, 6'b000010};
        for (int i = 0; i < 11; i++) begin
            op = ops[i];
            tests++;
            if (m_if.STATE !== 4'(exp_s[i])) begin
                fails++; $display("FAIL b2b_state[%0d]: got %0d expected %0d", i, m_if.STATE, exp_s[i]);
            end
            tests++;
            if (m_if.MEMWRITE !== (exp_s[i] == 5) || m_if.REGWRITE !== 1'b0) begin
                fails++; $display("FAIL b2b_mem[%0d]: got memwrite=%b regwrite=%b", i,
                    m_if.MEMWRITE, m_if.REGWRITE);
            end
            tests++;
            if (m_if.PCWRITECOND !== (exp_s[i] == 8)) begin
                fails++; $display("FAIL b2b_pcwritecond[%0d]: got %b", i, m_if.PCWRITECOND);
            end
            if (exp_s[i] == 8) begin
                tests++;
                if (m_if.PCSOURCE !== 2'b01 || m_if.ALUOP !== 2'b01 || m_if.ALUSRCA !== 1'b1) begin
                    fails++; $display("FAIL b2b_beq: got pcsource=%b aluop=%b alusrca=%b expected 01 01 1",
                        m_if.PCSOURCE, m_if.ALUOP, m_if.ALUSRCA);
                end
            end
            if (exp_s[i] == 9) begin
                tests++;
                if (m_if.PCWRITE !== 1'b1 || m_if.PCSOURCE !== 2'b10) begin
                    fails++; $display("FAIL b2b_jmp: got pcwrite=%b pcsource=%b expected 1 10",
                        m_if.PCWRITE, m_if.PCSOURCE);
                end
            end
            if (i < 10) @(negedge CLK);
        end
    endtask

    task automatic test_illegal();
        int exp_s[3] = '{0, 1, 0};
        op = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (m_if.STATE !== 4'(exp_s[i]) || n_if.STATE !== 4'(exp_s[i])) begin
                fails++; $display("FAIL ill_state[%0d]: got %0d/%0d expected %0d", i,
                    m_if.STATE, n_if.STATE, exp_s[i]);
            end
            tests++;
            if (m_if.ILLEGAL !== (exp_s[i] == 1) || n_if.ILLEGAL !== (exp_s[i] == 1)) begin
                fails++; $display("FAIL ill_flag[%0d]: got %b/%b expected %b", i,
                    m_if.ILLEGAL, n_if.ILLEGAL, exp_s[i] == 1);
            end
            tests++;
            if (m_if.REGWRITE !== 1'b0 || m_if.MEMWRITE !== 1'b0) begin
                fails++; $display("FAIL ill_write[%0d]: got regwrite=%b memwrite=%b expected 0 0",
                    i, m_if.REGWRITE, m_if.MEMWRITE);
            end
            if (i < 2) @(negedge CLK);
        end
    endtask

    task automatic test_addi();
        int m_s[5] = '{0, 1, 10, 11, 0};
        int n_s[5] = '{0, 1, 0, 1, 0};
        logic [1:0] m_b[5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
        op = 6'b001000;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (m_if.STATE !== 4'(m_s[i])) begin
                fails++; $display("FAIL addi_state[%0d]: got %0d expected %0d", i, m_if.STATE, m_s[i]);
            end
            tests++;
            if (n_if.STATE !== 4'(n_s[i])) begin
                fails++; $display("FAIL addi_off_state[%0d]: got %0d expected %0d", i, n_if.STATE, n_s[i]);
            end
            tests++;
            if (n_if.ILLEGAL !== (n_s[i] == 1) || m_if.ILLEGAL !== 1'b0) begin
                fails++; $display("FAIL addi_illegal[%0d]: got on=%b off=%b", i, m_if.ILLEGAL, n_if.ILLEGAL);
            end
            tests++;
            if (m_if.REGWRITE !== (m_s[i] == 11) || m_if.REGDST !== 1'b0 || m_if.MEMTOREG !== 1'b0
                || n_if.REGWRITE !== 1'b0 || n_if.MEMWRITE !== 1'b0) begin
                fails++; $display("FAIL addi_wb[%0d]: got regwrite=%b regdst=%b memtoreg=%b off_regwrite=%b",
                    i, m_if.REGWRITE, m_if.REGDST, m_if.MEMTOREG, n_if.REGWRITE);
            end
            tests++;
            if (m_if.ALUSRCB !== m_b[i]) begin
                fails++; $display("FAIL addi_alusrcb[%0d]: got %b expected %b", i, m_if.ALUSRCB, m_b[i]);
            end
            if (i < 4) @(negedge CLK);
        end
    endtask

    task automatic test_async_reset();
        op = 6'b100011;
        repeat (3) @(negedge CLK);
        tests++;
        if (m_if.STATE !== 4'd3 || m_if.MEMREAD !== 1'b1) begin
            fails++; $display("FAIL arst_pre: got state=%0d memread=%b expected 3 1", m_if.STATE, m_if.MEMREAD);
        end
        #2 RST = 1'b1;
        #1;
        tests++;
        if (m_if.STATE !== 4'd0 || m_if.MEMREAD !== 1'b0) begin
            fails++; $display("FAIL arst_immediate: got state=%0d memread=%b expected 0 0",
                m_if.STATE, m_if.MEMREAD);
        end
        @(posedge CLK);
        #1;
        tests++;
        if ({m_if.STATE, m_if.PCWRITE, m_if.MEMREAD, m_if.IRWRITE, m_if.REGWRITE, m_if.MEMWRITE}
            !== 9'b0) begin
            fails++; $display("FAIL arst_held: got %b expected 000000000",
                {m_if.STATE, m_if.PCWRITE, m_if.MEMREAD, m_if.IRWRITE, m_if.REGWRITE, m_if.MEMWRITE});
        end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        tests++;
        if (m_if.STATE !== 4'd0 || m_if.PCWRITE !== 1'b1) begin
            fails++; $display("FAIL arst_release: got state=%0d pcwrite=%b expected 0 1",
                m_if.STATE, m_if.PCWRITE);
        end
        @(negedge CLK);
        tests++;
        if (m_if.STATE !== 4'd1) begin
            fails++; $display("FAIL arst_resume: got %0d expected 1", m_if.STATE);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        RST   = 1'b1;
        op    = 6'b100011;
        test_reset();
        test_lw();
        test_rtype();
        test_back_to_back();
        test_illegal();
        test_addi();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
